// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
//   Shared definitions for the multi-cycle RISC-V control unit. It holds the
//   opcode constants, the FSM state enum, the instruction-class enum and the
//   datapath mux encodings. It also provides a helper that maps an instruction
//   class to its immediate format.
//   The optional JAL path is enabled by the MULTICYCLE_JAL_EN macro. That macro
//   is read in mc_op_class. Nothing in this package depends on it.
package riscv_ctrl_pkg;

  localparam int OPC_W = 7;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_RTYPE   = 3'd3,
    CLS_ITYPE   = 3'd4,
    CLS_BRANCH  = 3'd5,
    CLS_JAL     = 3'd6
  } op_class_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // Immediate format follows the instruction class. Loads, I-type ops and
  // anything unrecognised use the I-format.
  function automatic imm_src_e imm_src_of(input op_class_e cls);
    case (cls)
      CLS_STORE:  return IMM_S;
      CLS_BRANCH: return IMM_B;
      CLS_JAL:    return IMM_J;
      default:    return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_op_class.sv
// mc_op_class
//   Combinational decode from the opcode field to an instruction class. The
//   controller uses the class for the DECODE/MEMADR transitions and for the
//   ImmSrc output.
//   Configuration: with MULTICYCLE_JAL_EN defined, 1101111 decodes as JAL.
//   Otherwise it decodes as illegal.
// Ports:
//   op        in  OP_W  opcode field from the instruction register
//   op_class  out       decoded instruction class (op_class_e)
module mc_op_class
  import riscv_ctrl_pkg::*;
#(
  parameter int OP_W = 7
) (
  input  logic [OP_W-1:0] op,
  output op_class_e       op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (op)
      OP_W'(OPC_LOAD):   op_class = CLS_LOAD;
      OP_W'(OPC_STORE):  op_class = CLS_STORE;
      OP_W'(OPC_RTYPE):  op_class = CLS_RTYPE;
      OP_W'(OPC_ITYPE):  op_class = CLS_ITYPE;
      OP_W'(OPC_BRANCH): op_class = CLS_BRANCH;
`ifdef MULTICYCLE_JAL_EN
      OP_W'(OPC_JAL):    op_class = CLS_JAL;
`endif
      default:           op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore control FSM for the multi-cycle RISC-V core. It sequences one
//   instruction over the shared datapath and the single memory port. Memory
//   states hold while mem_ready is low.
//   Outputs are combinational from the state register. The exceptions are
//   IRWrite/PCWrite in FETCH (mem_ready), PCWrite in BRANCH (zero, funct3[0]),
//   illegal_op in DECODE (op) and ImmSrc (op, in every state).
//   Configuration: MULTICYCLE_JAL_EN enables the JAL state and the J-format
//   immediate. The macro is read in mc_op_class.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   op, funct3        instruction-register fields
//   zero              ALU zero flag (branch resolution)
//   mem_ready         memory completes the current access this cycle
//   mem_req           memory access requested
//   PCWrite, IRWrite, RegWrite, MemWrite   write enables / strobes
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp   datapath selects
//   illegal_op        one-cycle pulse in DECODE for an unsupported opcode
//   state_dbg         current state, debug only
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int OP_W    = 7,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic [2:0]         funct3,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         ALUOp,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  state_e      state_q, state_d;
  op_class_e   op_class;
  result_src_e result_src;
  alu_src_a_e  src_a;
  alu_src_b_e  src_b;
  alu_op_e     alu_op;

  // Only funct3[0] (BEQ/BNE) matters to this controller.
  logic unused_funct3;
  assign unused_funct3 = ^funct3[2:1];

  mc_op_class #(.OP_W(OP_W)) u_op_class (
    .op       (op),
    .op_class (op_class)
  );

  // Next-state logic.
  always_comb begin
    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned; that is what keeps latches from inferring.
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op_class)
          CLS_LOAD, CLS_STORE: state_d = S_MEMADR;
          CLS_RTYPE:           state_d = S_EXECR;
          CLS_ITYPE:           state_d = S_EXECI;
          CLS_BRANCH:          state_d = S_BRANCH;
          CLS_JAL:             state_d = S_JAL;
          default:             state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op_class == CLS_LOAD)       state_d = S_MEMREAD;
        else if (op_class == CLS_STORE) state_d = S_MEMWRITE;
        else                            state_d = S_FETCH;
      end
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode. Unlisted outputs stay 0 (selects at encoding 00).
  always_comb begin
    mem_req    = 1'b0;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    illegal_op = 1'b0;
    result_src = RES_ALUOUT;
    src_a      = SRCA_PC;
    src_b      = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        IRWrite    = mem_ready;
        PCWrite    = mem_ready;
        src_b      = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        src_a      = SRCA_OLDPC;
        src_b      = SRCB_IMM;
        illegal_op = (op_class == CLS_ILLEGAL);
      end
      S_MEMADR: begin
        src_a = SRCA_RS1;
        src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        RegWrite   = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        src_a  = SRCA_RS1;
        src_b  = SRCB_RS2;
        alu_op = ALUOP_FUNCT;
      end
      S_EXECI: begin
        src_a  = SRCA_RS1;
        src_b  = SRCB_IMM;
        alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        src_a   = SRCA_RS1;
        src_b   = SRCB_RS2;
        alu_op  = ALUOP_SUB;
        // BNE takes the branch when the operands differ, so its sense is
        // the inverse of the zero flag.
        PCWrite = zero ^ funct3[0];
      end
      S_JAL: begin
        src_a   = SRCA_OLDPC;
        src_b   = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      default: ;
    endcase

    // While reset is high, no strobe may fire, even mid-instruction.
    // The selects park at their FETCH values.
    if (rst) begin
      mem_req    = 1'b0;
      PCWrite    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      illegal_op = 1'b0;
      AdrSrc     = 1'b0;
      result_src = RES_ALURESULT;
      src_a      = SRCA_PC;
      src_b      = SRCB_FOUR;
      alu_op     = ALUOP_ADD;
    end
  end

  assign ResultSrc = result_src;
  assign ALUSrcA   = src_a;
  assign ALUSrcB   = src_b;
  assign ALUOp     = alu_op;
  assign ImmSrc    = imm_src_of(op_class);
  assign state_dbg = STATE_W'(state_q);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values, independent of block evaluation order.
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Directed bench for multicycle_controller. Each stimulus cycle queues the
//   expected state, the control vector and ImmSrc for that cycle. A monitor
//   on the falling edge pops each entry and compares it against the DUT.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp;
  logic [3:0] state_dbg;

  multicycle_controller #(.OP_W(7), .STATE_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUOp      (ALUOp),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // Control vector:
  // {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
  //  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal_op}
  localparam logic [14:0] V_RESET      = {6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [14:0] V_FETCH_WAIT = {6'b100000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [14:0] V_FETCH_GO   = {6'b110010, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [14:0] V_DECODE     = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
  localparam logic [14:0] V_DECODE_ILL = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b1};
  localparam logic [14:0] V_MEMADR     = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
  localparam logic [14:0] V_MEMREAD    = {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_MEMWB      = {6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_MEMWRITE   = {6'b101100, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_EXECR      = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
  localparam logic [14:0] V_EXECI      = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0};
  localparam logic [14:0] V_ALUWB      = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_BR_TAKEN   = {6'b010000, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
  localparam logic [14:0] V_BR_NOT     = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
  localparam logic [14:0] V_JAL        = {6'b010000, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [14:0] vec;
    logic [1:0]  imm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Instruction fields applied by the next cyc() call.
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic [1:0] cur_imm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge and queue the
  // expected response for the state entered at that edge.
  task automatic cyc(input string tag, input logic r, input logic mr, input logic z,
                     input state_e st, input logic [14:0] vec);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    mem_ready = mr;
    zero      = z;
    op        = cur_op;
    funct3    = cur_f3;
    e.tag = tag;
    e.st  = st;
    e.vec = vec;
    e.imm = cur_imm;
    exp_q.push_back(e);
  endtask

  // Monitor / scoreboard.
  exp_t        got;
  logic [14:0] act_vec;
  assign act_vec = {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                    ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal_op};

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      got = exp_q.pop_front();
      check({got.tag, ".state"}, 32'(state_dbg), 32'(got.st));
      check({got.tag, ".ctrl"},  32'(act_vec),   32'(got.vec));
      check({got.tag, ".imm"},   32'(ImmSrc),    32'(got.imm));
    end
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b0; zero = 1'b0;
    op = OPC_RTYPE; funct3 = 3'b000;
    cur_op = OPC_RTYPE; cur_f3 = 3'b000; cur_imm = 2'b00;

    // Reset, then R-type: FETCH, DECODE, EXECR, ALUWB.
    cyc("reset",      1'b1, 1'b0, 1'b0, S_FETCH,  V_RESET);
    cyc("r_fetch",    1'b0, 1'b1, 1'b0, S_FETCH,  V_FETCH_GO);
    cyc("r_decode",   1'b0, 1'b1, 1'b0, S_DECODE, V_DECODE);
    cyc("r_exec",     1'b0, 1'b1, 1'b0, S_EXECR,  V_EXECR);
    cyc("r_wb",       1'b0, 1'b1, 1'b0, S_ALUWB,  V_ALUWB);

    // Load with two wait cycles in MEMREAD: 7 cycles.
    cur_op = OPC_LOAD; cur_imm = 2'b00;
    cyc("ld_fetch",   1'b0, 1'b1, 1'b0, S_FETCH,   V_FETCH_GO);
    cyc("ld_decode",  1'b0, 1'b1, 1'b0, S_DECODE,  V_DECODE);
    cyc("ld_adr",     1'b0, 1'b1, 1'b0, S_MEMADR,  V_MEMADR);
    cyc("ld_rd_w0",   1'b0, 1'b0, 1'b0, S_MEMREAD, V_MEMREAD);
    cyc("ld_rd_w1",   1'b0, 1'b0, 1'b0, S_MEMREAD, V_MEMREAD);
    cyc("ld_rd",      1'b0, 1'b1, 1'b0, S_MEMREAD, V_MEMREAD);
    cyc("ld_wb",      1'b0, 1'b1, 1'b0, S_MEMWB,   V_MEMWB);

    // Branches: BNE zero=0 taken, BEQ zero=0 not taken,
    // BEQ zero=1 taken, BNE zero=1 not taken.
    cur_op = OPC_BRANCH; cur_imm = 2'b10; cur_f3 = 3'b001;
    cyc("bne0_fetch", 1'b0, 1'b1, 1'b0, S_FETCH,  V_FETCH_GO);
    cyc("bne0_dec",   1'b0, 1'b1, 1'b0, S_DECODE, V_DECODE);
    cyc("bne0_br",    1'b0, 1'b1, 1'b0, S_BRANCH, V_BR_TAKEN);
    cur_f3 = 3'b000;
    cyc("beq0_fetch", 1'b0, 1'b1, 1'b0, S_FETCH,  V_FETCH_GO);
    cyc("beq0_dec",   1'b0, 1'b1, 1'b0, S_DECODE, V_DECODE);
    cyc("beq0_br",    1'b0, 1'b1, 1'b0, S_BRANCH, V_BR_NOT);
    cyc("beq1_fetch", 1'b0, 1'b1, 1'b0, S_FETCH,  V_FETCH_GO);
    cyc("beq1_dec",   1'b0, 1'b1, 1'b0, S_DECODE, V_DECODE);
    cyc("beq1_br",    1'b0, 1'b1, 1'b1, S_BRANCH, V_BR_TAKEN);
    cur_f3 = 3'b001;
    cyc("bne1_fetch", 1'b0, 1'b1, 1'b0, S_FETCH,  V_FETCH_GO);
    cyc("bne1_dec",   1'b0, 1'b1, 1'b0, S_DECODE, V_DECODE);
    cyc("bne1_br",    1'b0, 1'b1, 1'b1, S_BRANCH, V_BR_NOT);

    // Illegal opcode: one-cycle pulse in DECODE, straight back to FETCH.
    cur_op = 7'b1111111; cur_imm = 2'b00; cur_f3 = 3'b000;
    cyc("ill_fetch",  1'b0, 1'b1, 1'b0, S_FETCH,  V_FETCH_GO);
    cyc("ill_dec",    1'b0, 1'b1, 1'b0, S_DECODE, V_DECODE_ILL);

    // JAL: full path when enabled, illegal pulse otherwise.
    cur_op = OPC_JAL;
`ifdef MULTICYCLE_JAL_EN
    cur_imm = 2'b11;
    cyc("jal_fetch",  1'b0, 1'b1, 1'b0, S_FETCH,  V_FETCH_GO);
    cyc("jal_dec",    1'b0, 1'b1, 1'b0, S_DECODE, V_DECODE);
    cyc("jal_jal",    1'b0, 1'b1, 1'b0, S_JAL,    V_JAL);
    cyc("jal_wb",     1'b0, 1'b1, 1'b0, S_ALUWB,  V_ALUWB);
`else
    cur_imm = 2'b00;
    cyc("jal_fetch",  1'b0, 1'b1, 1'b0, S_FETCH,  V_FETCH_GO);
    cyc("jal_dec",    1'b0, 1'b1, 1'b0, S_DECODE, V_DECODE_ILL);
`endif

    // I-type with one FETCH wait. mem_ready toggles in states that
    // ignore it.
    cur_op = OPC_ITYPE; cur_imm = 2'b00;
    cyc("i_fetch_w",  1'b0, 1'b0, 1'b0, S_FETCH,  V_FETCH_WAIT);
    cyc("i_fetch",    1'b0, 1'b1, 1'b0, S_FETCH,  V_FETCH_GO);
    cyc("i_decode",   1'b0, 1'b0, 1'b0, S_DECODE, V_DECODE);
    cyc("i_exec",     1'b0, 1'b1, 1'b0, S_EXECI,  V_EXECI);
    cyc("i_wb",       1'b0, 1'b0, 1'b1, S_ALUWB,  V_ALUWB);

    // Store with one MEMWRITE wait.
    cur_op = OPC_STORE; cur_imm = 2'b01;
    cyc("st_fetch",   1'b0, 1'b1, 1'b0, S_FETCH,    V_FETCH_GO);
    cyc("st_decode",  1'b0, 1'b1, 1'b0, S_DECODE,   V_DECODE);
    cyc("st_adr",     1'b0, 1'b1, 1'b0, S_MEMADR,   V_MEMADR);
    cyc("st_wr_w0",   1'b0, 1'b0, 1'b0, S_MEMWRITE, V_MEMWRITE);
    cyc("st_wr",      1'b0, 1'b1, 1'b0, S_MEMWRITE, V_MEMWRITE);

    // Store aborted by reset while waiting in MEMWRITE.
    cyc("rs_fetch",   1'b0, 1'b1, 1'b0, S_FETCH,    V_FETCH_GO);
    cyc("rs_decode",  1'b0, 1'b1, 1'b0, S_DECODE,   V_DECODE);
    cyc("rs_adr",     1'b0, 1'b1, 1'b0, S_MEMADR,   V_MEMADR);
    cyc("rs_wr_w0",   1'b0, 1'b0, 1'b0, S_MEMWRITE, V_MEMWRITE);
    cyc("rs_wr_rst",  1'b1, 1'b0, 1'b0, S_MEMWRITE, V_RESET);
    cyc("rs_after",   1'b0, 1'b1, 1'b0, S_FETCH,    V_FETCH_GO);
    cyc("rs_decode2", 1'b0, 1'b1, 1'b0, S_DECODE,   V_DECODE);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multi-cycle RISC-V core. It replaces the purely combinational single-cycle decoder with a Moore state machine that sequences one instruction across several cycles over a shared datapath and a single memory port. It also adds:
- a `mem_req`/`mem_ready` wait-state handshake;
- BNE alongside BEQ;
- illegal-opcode reporting;
- an optional JAL path.

It sits between the instruction register (op, funct3) and the datapath mux/enable controls.

## Interface
Parameters:
- `OP_W`, 7, opcode field width.
- `STATE_W`, 4, state register width; must encode all states.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op`  in  OP_W  opcode from the instruction register (valid from Decode onward).
- `funct3`  in  3  funct3 from the instruction register; bit 0 selects BEQ (0) or BNE (1).
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access requested.
- `PCWrite`  out  1  PC register enable.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemWrite`  out  1  store strobe.
- `IRWrite`  out  1  instruction-register / OldPC enable.
- `RegWrite`  out  1  register-file write enable.
- `ResultSrc`  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB`  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- `ImmSrc`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `ALUOp`  out  2  to the ALU decoder: 00 = add, 01 = sub/compare, 10 = funct-decoded.
- `illegal_op`  out  1  one-cycle pulse for an unsupported opcode.
- `state_dbg`  out  STATE_W  current state, for debug only.

## Operation
States and transitions:
- **FETCH**: `mem_req`=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCWrite equal `mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- **DECODE**: ALUSrcA=01, ALUSrcB=01, ALUOp=00; computes OldPC+imm into ALUOut. Next state by opcode:
  - 0000011 (load) or 0100011 (store) → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BRANCH.
  - 1101111 → JAL (only with the JAL feature enabled).
  - Any other opcode → FETCH, with `illegal_op`=1 for this cycle.
- **MEMADR**: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD for a load, MEMWRITE for a store.
- **MEMREAD**: `mem_req`=1, AdrSrc=1, ResultSrc=00. Holds until `mem_ready`, then goes to MEMWB.
- **MEMWB**: ResultSrc=01, RegWrite=1, then FETCH.
- **MEMWRITE**: `mem_req`=1, AdrSrc=1, ResultSrc=00, MemWrite=1 for every cycle the state is held. Holds until `mem_ready`, then FETCH.
- **EXECR**: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- **EXECI**: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- **ALUWB**: ResultSrc=00, RegWrite=1, then FETCH.
- **BRANCH**: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite = `zero` XOR `funct3[0]`.
  - Goes to FETCH.
- **JAL**: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then ALUWB.

Output rules:
- ImmSrc is decoded from `op` in every state: S-type → 01, branch → 10, JAL → 11, else 00.
- Every output not listed for a state is 0.
- Outputs are combinational from state, plus `mem_ready`/`zero`/`funct3`/`op` where stated above.

## Timing
- Reset:
  - `rst` sampled high → state = FETCH on the next edge.
  - While `rst` is high, all enables are forced to 0: `mem_req`, PCWrite, IRWrite, MemWrite, RegWrite, `illegal_op`.
  - Mux selects take their FETCH values during reset.
- Reset mid-instruction aborts the instruction; no write strobe fires in the cycle `rst` is high.
- Zero-wait latency, FETCH to the next FETCH:
  - load 5 cycles;
  - store, R-type, I-type and JAL 4 cycles;
  - branch 3 cycles;
  - illegal opcode 2 cycles.
- Each cycle `mem_ready` is low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Outputs are held stable while waiting.
- `mem_ready` is ignored in states that do not assert `mem_req`.

## Configuration
- `MULTICYCLE_JAL_EN` defined:
  - JAL state and ImmSrc=11 decoding are present.
  - JAL writes OldPC+4 to rd and OldPC+imm to PC.
- Undefined:
  - 1101111 is illegal (`illegal_op` pulse, return to FETCH).
  - ImmSrc never drives 11.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - opcode constants;
  - the state enum;
  - the ResultSrc, ALUSrcA, ALUSrcB, ImmSrc and ALUOp encodings.
- One sub-module, `mc_op_class`: combinational opcode → instruction-class decode. It is used by the DECODE transition logic and the ImmSrc logic.

## Test plan
- Reset, `mem_ready`=1, `op`=0110011 → states FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in cycle 4; ALUOp=10 in cycle 3.
- Load with `mem_ready` low for 2 cycles in MEMREAD → 7 cycles total; MEMWB asserts ResultSrc=01, RegWrite=1.
- BNE (funct3=001), `zero`=0 → PCWrite=1 in BRANCH. BEQ with `zero`=0 → PCWrite=0.
- `op`=1111111 → `illegal_op` high for exactly 1 cycle in DECODE; FETCH on the next cycle; no write strobes.
- JAL with `MULTICYCLE_JAL_EN` → DECODE, JAL (PCWrite=1), ALUWB (RegWrite=1), 4 cycles. Without the macro → `illegal_op` pulse.
- `rst` asserted during MEMWRITE with `mem_ready`=0 → MemWrite=0 that cycle; FETCH next cycle.
